// File: rtl/tx_sequence_emitter.sv
// -----------------------------------------------------------------------------
// tx_sequence_emitter
//
// Purpose:
//   Emits one PRBS-spread carrier burst per transmission request. Each
//   transmission is CHIPS chips of a 9-bit Fibonacci LFSR (x^9 + x^5 + 1),
//   SAMPLES_PER_CHIP DAC samples per chip. Sample k is
//   carrier[k mod 4] * sign, where carrier = {0, +AMPLITUDE, 0, -AMPLITUDE}
//   and sign is +1 for chip 1 and -1 for chip 0. One sample is produced per
//   DAC strobe (inew_sample_trigger). A completion flag is raised at the end
//   and held until the consumer acknowledges it.
//
// Optional feature:
//   TX_GUARD_SILENCE_EN - when defined, GUARD_SAMPLES zero-valued samples are
//   emitted after the burst (o_busy stays high) before completion. When not
//   defined, the burst goes straight to completion and GUARD_SAMPLES is unused.
//
// Parameters:
//   CHIPS            PRBS chips per transmission
//   SAMPLES_PER_CHIP samples per chip, nonzero multiple of 4
//   AMPLITUDE        peak carrier value (signed 16-bit range)
//   GUARD_SAMPLES    zero-sample tail length (guard build only)
//
// Ports:
//   ctx_clk             clock
//   rtx_rst             asynchronous active-high reset (release is synchronous)
//   etx_en              enable; low aborts to IDLE and clears all outputs
//   inew_sample_trigger one-cycle DAC sample strobe
//   icurrent_time       free-running timestamp
//   istart              transmission request, honoured in IDLE only
//   iseq_sel            sequence index, latched with istart
//   iresult_acquired    acknowledges (clears) o_trigger_done
//   o_sample            signed DAC sample
//   o_sample_valid      one-cycle pulse per new o_sample
//   o_busy              high in ARM, SEND or GUARD
//   o_seq               latched sequence index
//   o_time_start        timestamp of the first emitted sample
//   o_trigger_done      transmission-complete flag
// -----------------------------------------------------------------------------
module tx_sequence_emitter #(
  parameter int CHIPS            = 511,
  parameter int SAMPLES_PER_CHIP = 4,
  parameter int AMPLITUDE        = 8000,
  parameter int GUARD_SAMPLES    = 1000
) (
  input  logic               ctx_clk,
  input  logic               rtx_rst,
  input  logic               etx_en,
  input  logic               inew_sample_trigger,
  input  logic [31:0]        icurrent_time,
  input  logic               istart,
  input  logic [3:0]         iseq_sel,
  input  logic               iresult_acquired,
  output logic signed [15:0] o_sample,
  output logic               o_sample_valid,
  output logic               o_busy,
  output logic [3:0]         o_seq,
  output logic [31:0]        o_time_start,
  output logic               o_trigger_done
);

  // ---------------------------------------------------------------------------
  // Sizing
  // ---------------------------------------------------------------------------
  localparam int TX_SAMPLES = CHIPS * SAMPLES_PER_CHIP;

`ifdef TX_GUARD_SILENCE_EN
  localparam int CNT_MAX      = (TX_SAMPLES > GUARD_SAMPLES) ? TX_SAMPLES : GUARD_SAMPLES;
  localparam bit GUARD_ACTIVE = (GUARD_SAMPLES > 0);
`else
  // The guard length has no influence on sizing when the tail is not built.
  localparam int CNT_MAX      = TX_SAMPLES + 0 * GUARD_SAMPLES;
`endif

  // One sample counter serves both the burst and the guard tail; it is sized
  // so that its largest terminal value fits and it never wraps.
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam int PH_W  = $clog2(SAMPLES_PER_CHIP);

  localparam logic [CNT_W-1:0] TX_LAST = CNT_W'(TX_SAMPLES - 1);
  localparam logic [PH_W-1:0]  PH_LAST = PH_W'(SAMPLES_PER_CHIP - 1);
`ifdef TX_GUARD_SILENCE_EN
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'((GUARD_SAMPLES > 0) ? GUARD_SAMPLES - 1 : 0);
`endif

  localparam logic signed [15:0] AMP_POS = 16'(AMPLITUDE);
  localparam logic signed [15:0] AMP_NEG = 16'(-AMPLITUDE);

  localparam logic [8:0] LFSR_RESET = 9'h001;

  // ---------------------------------------------------------------------------
  // FSM encoding
  // ---------------------------------------------------------------------------
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARM   = 3'd1;
  localparam logic [2:0] ST_SEND  = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
`ifdef TX_GUARD_SILENCE_EN
  localparam logic [2:0] ST_GUARD = 3'd4;
`endif

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [2:0]         state_reg,  state_next;
  logic [8:0]         lfsr_reg,   lfsr_next;
  logic [CNT_W-1:0]   cnt_reg,    cnt_next;
  logic [PH_W-1:0]    phase_reg,  phase_next;
  logic signed [15:0] sample_reg, sample_next;
  logic               valid_reg,  valid_next;
  logic [3:0]         seq_reg,    seq_next;
  logic [31:0]        time_reg,   time_next;
  logic               done_reg,   done_next;

  // ---------------------------------------------------------------------------
  // Carrier table {0, +A, 0, -A}
  // ---------------------------------------------------------------------------
  logic signed [15:0] carrier [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_carrier
      if (gi == 1) begin : g_pos
        assign carrier[gi] = AMP_POS;
      end else if (gi == 3) begin : g_neg
        assign carrier[gi] = AMP_NEG;
      end else begin : g_zero
        assign carrier[gi] = '0;
      end
    end
  endgenerate

  // Burst sample for the current index. SAMPLES_PER_CHIP is a multiple of 4,
  // so the low two bits of the transmission-wide index select the carrier
  // phase directly.
  logic signed [15:0] carrier_val;
  logic signed [15:0] chip_sample;
  logic [8:0]         lfsr_step;

  always_comb begin
    carrier_val = carrier[cnt_reg[1:0]];
    chip_sample = lfsr_reg[8] ? carrier_val : -carrier_val;
  end

  // x^9 + x^5 + 1: feedback from bits 8 and 4, shifted in at the bottom.
  assign lfsr_step = {lfsr_reg[7:0], lfsr_reg[8] ^ lfsr_reg[4]};

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    lfsr_next   = lfsr_reg;
    cnt_next    = cnt_reg;
    phase_next  = phase_reg;
    sample_next = '0;
    valid_next  = 1'b0;
    seq_next    = seq_reg;
    time_next   = time_reg;
    done_next   = done_reg;

    // The acknowledge is applied first so that a set in DONE below overrides it.
    if (iresult_acquired) begin
      done_next = 1'b0;
    end

    case (state_reg)
      ST_IDLE: begin
        if (istart) begin
          state_next = ST_ARM;
          seq_next   = iseq_sel;
          // The low seed bits are constant-nonzero, so the LFSR never locks up.
          lfsr_next  = {iseq_sel, 5'b10101};
          cnt_next   = '0;
          phase_next = '0;
        end
      end

      // The strobe that moves ARM to SEND also produces sample 0 and defines
      // the transmission timestamp.
      ST_ARM, ST_SEND: begin
        sample_next = sample_reg;
        if (inew_sample_trigger) begin
          valid_next  = 1'b1;
          sample_next = chip_sample;
          if (state_reg == ST_ARM) begin
            time_next = icurrent_time;
          end

          if (phase_reg == PH_LAST) begin
            phase_next = '0;
            lfsr_next  = lfsr_step;
          end else begin
            phase_next = phase_reg + PH_W'(1);
          end

          if (cnt_reg == TX_LAST) begin
            cnt_next = '0;
`ifdef TX_GUARD_SILENCE_EN
            state_next = GUARD_ACTIVE ? ST_GUARD : ST_DONE;
`else
            state_next = ST_DONE;
`endif
          end else begin
            cnt_next   = cnt_reg + CNT_W'(1);
            state_next = ST_SEND;
          end
        end
      end

`ifdef TX_GUARD_SILENCE_EN
      // Silent tail: strobes still produce valid pulses, with zero samples.
      ST_GUARD: begin
        if (inew_sample_trigger) begin
          valid_next = 1'b1;
          if (cnt_reg == GUARD_LAST) begin
            cnt_next   = '0;
            state_next = ST_DONE;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end
`endif

      ST_DONE: begin
        done_next  = 1'b1;
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Disable overrides everything: abort with no completion flag.
    if (!etx_en) begin
      state_next  = ST_IDLE;
      lfsr_next   = LFSR_RESET;
      cnt_next    = '0;
      phase_next  = '0;
      sample_next = '0;
      valid_next  = 1'b0;
      seq_next    = '0;
      time_next   = '0;
      done_next   = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge ctx_clk or posedge rtx_rst) begin
    if (rtx_rst) begin
      state_reg  <= ST_IDLE;
      lfsr_reg   <= LFSR_RESET;
      cnt_reg    <= '0;
      phase_reg  <= '0;
      sample_reg <= '0;
      valid_reg  <= 1'b0;
      seq_reg    <= '0;
      time_reg   <= '0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      lfsr_reg   <= lfsr_next;
      cnt_reg    <= cnt_next;
      phase_reg  <= phase_next;
      sample_reg <= sample_next;
      valid_reg  <= valid_next;
      seq_reg    <= seq_next;
      time_reg   <= time_next;
      done_reg   <= done_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_sample       = sample_reg;
  assign o_sample_valid = valid_reg;
  assign o_seq          = seq_reg;
  assign o_time_start   = time_reg;
  assign o_trigger_done = done_reg;

`ifdef TX_GUARD_SILENCE_EN
  assign o_busy = (state_reg == ST_ARM) || (state_reg == ST_SEND) || (state_reg == ST_GUARD);
`else
  assign o_busy = (state_reg == ST_ARM) || (state_reg == ST_SEND);
`endif

endmodule

// File: tb/tb_tx_sequence_emitter.sv
// -----------------------------------------------------------------------------
// Testbench for tx_sequence_emitter.
// Expected samples come from a bench-side PRBS/carrier model and are queued
// when each strobe is driven; a monitor pops and compares on every
// o_sample_valid pulse. Works with or without TX_GUARD_SILENCE_EN.
// -----------------------------------------------------------------------------
module tb_tx_sequence_emitter;

  localparam int CHIPS = 511;
  localparam int SPC   = 4;
  localparam int AMP   = 8000;
  localparam int GS    = 10;
  localparam int NTX   = CHIPS * SPC;
`ifdef TX_GUARD_SILENCE_EN
  localparam int NGUARD = GS;
`else
  localparam int NGUARD = 0;
`endif

  logic               clk;
  logic               rst;
  logic               en;
  logic               trig;
  logic [31:0]        cur_time;
  logic               start;
  logic [3:0]         sel;
  logic               ack;
  logic signed [15:0] sample;
  logic               sample_valid;
  logic               busy;
  logic [3:0]         seq;
  logic [31:0]        time_start;
  logic               done;

  tx_sequence_emitter #(
    .CHIPS            (CHIPS),
    .SAMPLES_PER_CHIP (SPC),
    .AMPLITUDE        (AMP),
    .GUARD_SAMPLES    (GS)
  ) dut (
    .ctx_clk             (clk),
    .rtx_rst             (rst),
    .etx_en              (en),
    .inew_sample_trigger (trig),
    .icurrent_time       (cur_time),
    .istart              (start),
    .iseq_sel            (sel),
    .iresult_acquired    (ack),
    .o_sample            (sample),
    .o_sample_valid      (sample_valid),
    .o_busy              (busy),
    .o_seq               (seq),
    .o_time_start        (time_start),
    .o_trigger_done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic signed [15:0] exp_q [$];
  int                 valid_cnt = 0;
  int                 cap_idx   = 4;
  logic signed [15:0] cap [4];

  // Bench model state
  logic [8:0] m_lfsr;
  int         m_k;
  logic [31:0] ts;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask

  // Expected value of the next sample according to the PRBS/carrier definition.
  task automatic push_expected();
    int carrier;
    int s;
    if (m_k < NTX) begin
      case (m_k % 4)
        1:       carrier = AMP;
        3:       carrier = -AMP;
        default: carrier = 0;
      endcase
      s = (m_lfsr[8] == 1'b1) ? carrier : -carrier;
      if ((m_k % SPC) == SPC - 1) begin
        m_lfsr = {m_lfsr[7:0], m_lfsr[8] ^ m_lfsr[4]};
      end
    end else begin
      s = 0;
    end
    exp_q.push_back(16'(s));
    m_k++;
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic start_tx(input logic [3:0] s);
    start = 1'b1;
    sel   = s;
    @(posedge clk); #1;
    start  = 1'b0;
    m_lfsr = {s, 5'b10101};
    m_k    = 0;
  endtask

  // One DAC strobe every 8 clocks; the sample is consumed at the final edge.
  task automatic strobe();
    repeat (7) @(posedge clk);
    #1;
    check("busy_at_strobe", busy, 1);
    cur_time = ts;
    trig     = 1'b1;
    push_expected();
    @(posedge clk); #1;
    trig = 1'b0;
    ts   = ts + 32'd8;
  endtask

  initial begin
    rst      = 1'b1;
    en       = 1'b1;
    trig     = 1'b0;
    cur_time = '0;
    start    = 1'b0;
    sel      = '0;
    ack      = 1'b0;
    ts       = 32'd1000;

    // Monitor and watchdog run alongside the directed sequence.
    fork
      forever begin
        @(negedge clk);
        if (sample_valid === 1'b1) begin
          valid_cnt++;
          if (cap_idx < 4) begin
            cap[cap_idx] = sample;
            cap_idx++;
          end
          n_cmp++;
          assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL sb_unexpected_valid: observed valid=1 expected no pulse (count %0d)", valid_cnt);
          end
          if (exp_q.size() != 0) begin
            check("sample", sample, exp_q.pop_front());
          end
        end
      end
      begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
      end
    join_none

    // ---- Reset state ----
    repeat (3) @(posedge clk);
    #1;
    check("rst_sample", sample, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_seq", seq, 0);
    check("rst_time", time_start, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // ---- T1: full transmission, seq 3, seed 9'h075 ----
    start_tx(4'd3);
    check("t1_busy_arm", busy, 1);
    check("t1_seq", seq, 3);
    cap_idx   = 0;
    valid_cnt = 0;
    for (int i = 0; i < NTX + NGUARD; i++) begin
      strobe();
      if (i == 0) check("t1_time_start", time_start, 1000);
      if (i == 50) begin
        // Request while busy must be ignored.
        start = 1'b1;
        sel   = 4'd9;
        @(posedge clk); #1;
        start = 1'b0;
        check("t1_seq_after_ignored_start", seq, 3);
      end
      if (i == NTX + NGUARD - 2) check("t1_done_early", done, 0);
    end
    // Now in the completion cycle: flag not yet visible; ack coincides with set.
    check("t1_done_not_yet", done, 0);
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
    check("t1_done_set_wins", done, 1);
    check("t1_busy_after", busy, 0);
    check("t1_sample_idle", sample, 0);
    check("t1_valid_count", valid_cnt, NTX + NGUARD);
    check("t1_time_hold", time_start, 1000);
    check("t1_first0", cap[0], 0);
    check("t1_first1", cap[1], -8000);
    check("t1_first2", cap[2], 0);
    check("t1_first3", cap[3], 8000);
    repeat (3) @(posedge clk);
    #1;
    check("t1_done_held", done, 1);

    // ---- T2: new start keeps pending done; ack clears; abort at sample 100 ----
    start_tx(4'd5);
    check("t2_done_pending", done, 1);
    check("t2_seq", seq, 5);
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
    check("t2_done_cleared", done, 0);
    for (int i = 0; i < 100; i++) strobe();
    en = 1'b0;
    @(posedge clk); #1;
    en = 1'b1;
    check("t2_abort_busy", busy, 0);
    check("t2_abort_sample", sample, 0);
    check("t2_abort_valid", sample_valid, 0);
    check("t2_abort_done", done, 0);
    check("t2_abort_seq", seq, 0);
    check("t2_abort_time", time_start, 0);
    check("t2_queue_drained", exp_q.size(), 0);
    repeat (20) @(posedge clk);
    #1;
    check("t2_done_stays0", done, 0);
    check("t2_busy_stays0", busy, 0);

    // ---- T3: asynchronous reset mid-SEND ----
    start_tx(4'd12);
    for (int i = 0; i < 30; i++) strobe();
    check("t3_busy_before", busy, 1);
    check("t3_seq_before", seq, 12);
    #3;
    rst = 1'b1;
    #1;
    check("t3_async_busy", busy, 0);
    check("t3_async_sample", sample, 0);
    check("t3_async_valid", sample_valid, 0);
    check("t3_async_seq", seq, 0);
    check("t3_async_time", time_start, 0);
    check("t3_async_done", done, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("t3_idle_after_release", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
